// File: rtl/tlb_pkg.sv
// Shared types and field layout for the TLB op sequencer.
// Op encodings, TLBEHI/TLBELO packing and FSM state type.
package tlb_pkg;

  localparam logic [2:0] TLBOP_SRCH = 3'd0;
  localparam logic [2:0] TLBOP_RD   = 3'd1;
  localparam logic [2:0] TLBOP_WR   = 3'd2;
  localparam logic [2:0] TLBOP_FILL = 3'd3;
  localparam logic [2:0] TLBOP_INV  = 3'd4;

  localparam logic [5:0] ECODE_TLBR = 6'h3F;

  localparam int VPPN_W = 19;
  localparam int PS_W   = 6;
  localparam int ASID_W = 10;
  localparam int PPN_W  = 20;
  localparam int HI_W   = VPPN_W + PS_W + ASID_W;
  localparam int LO_W   = PPN_W + 6;

  localparam int HI_ASID_LSB = 0;
  localparam int HI_PS_LSB   = 10;
  localparam int HI_VPPN_LSB = 16;

  localparam int LO_V       = 0;
  localparam int LO_D       = 1;
  localparam int LO_MAT_LSB = 2;
  localparam int LO_PLV_LSB = 4;
  localparam int LO_PPN_LSB = 6;

  localparam int ELO_V       = 0;
  localparam int ELO_D       = 1;
  localparam int ELO_PLV_LSB = 2;
  localparam int ELO_MAT_LSB = 4;
  localparam int ELO_G       = 6;
  localparam int ELO_PPN_LSB = 8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXEC,
    ST_RESP
  } state_e;

  typedef struct packed {
    logic [2:0]        op;
    logic [4:0]        inv_op;
    logic [ASID_W-1:0] inv_asid;
    logic [VPPN_W-1:0] inv_vppn;
    logic [ASID_W-1:0] asid;
    logic [VPPN_W-1:0] vppn;
    logic [PS_W-1:0]   ps;
    logic              w_e;
    logic              g;
    logic [LO_W-1:0]   lo0;
    logic [LO_W-1:0]   lo1;
  } tlb_req_t;

  typedef struct packed {
    logic            found;
    logic            e;
    logic [HI_W-1:0] hi;
    logic            g;
    logic [LO_W-1:0] lo0;
    logic [LO_W-1:0] lo1;
  } tlb_res_t;

  function automatic logic [LO_W-1:0] elo2lo(input logic [31:0] elo);
    logic unused_bits;
    unused_bits = ^{elo[31:28], elo[7:6]};
    return {elo[ELO_PPN_LSB +: PPN_W],
            elo[ELO_PLV_LSB +: 2],
            elo[ELO_MAT_LSB +: 2],
            elo[ELO_D],
            elo[ELO_V]};
  endfunction

  function automatic logic [31:0] lo2elo(input logic [LO_W-1:0] lo,
                                         input logic g);
    return {4'b0,
            lo[LO_PPN_LSB +: PPN_W],
            1'b0,
            g,
            lo[LO_MAT_LSB +: 2],
            lo[LO_PLV_LSB +: 2],
            lo[LO_D],
            lo[LO_V]};
  endfunction

endpackage

// File: rtl/tlb_fill_ctr.sv
// Free-running TLBFILL victim index, wraps N-1 -> 0.
// Advances every cycle regardless of traffic.
module tlb_fill_ctr #(
  parameter int N = 16,
  localparam int W = $clog2(N)
) (
  input  logic         clk,
  input  logic         resetn,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = (cnt_q == W'(N - 1)) ? '0 : cnt_q + W'(1);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/tlb_op_ctrl.sv
// TLB management op sequencer: accept, drive TLB one cycle,
// then return CSR writeback fields one cycle later.
module tlb_op_ctrl
  import tlb_pkg::*;
#(
  parameter int TLBNUM = 16,
  localparam int IDXW = $clog2(TLBNUM)
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [2:0]      req_op,
  input  logic [4:0]      req_inv_op,
  input  logic [9:0]      req_inv_asid,
  input  logic [18:0]     req_inv_vppn,
  input  logic [9:0]      csr_asid,
  input  logic [18:0]     csr_ehi_vppn,
  input  logic [IDXW-1:0] csr_idx,
  input  logic [5:0]      csr_ps,
  input  logic            csr_ne,
  input  logic [5:0]      csr_ecode,
  input  logic [31:0]     csr_elo0,
  input  logic [31:0]     csr_elo1,
  output logic            s_sel,
  output logic [18:0]     s_vppn,
  output logic [9:0]      s_asid,
  input  logic            s_found,
  input  logic [IDXW-1:0] s_index,
  output logic            tlb_we,
  output logic [IDXW-1:0] tlb_w_index,
  output logic            tlb_w_e,
  output logic [34:0]     tlb_w_hi,
  output logic            tlb_w_g,
  output logic [25:0]     tlb_w_lo0,
  output logic [25:0]     tlb_w_lo1,
  output logic [IDXW-1:0] tlb_r_index,
  input  logic            tlb_r_e,
  input  logic [34:0]     tlb_r_hi,
  input  logic            tlb_r_g,
  input  logic [25:0]     tlb_r_lo0,
  input  logic [25:0]     tlb_r_lo1,
  output logic            inv_valid,
  output logic [4:0]      inv_op,
  output logic            resp_valid,
  output logic            wb_idx_we,
  output logic            wb_ehi_we,
  output logic            wb_elo_we,
  output logic            wb_asid_we,
  output logic [IDXW-1:0] wb_idx,
  output logic [5:0]      wb_ps,
  output logic            wb_ne,
  output logic [18:0]     wb_ehi_vppn,
  output logic [31:0]     wb_elo0,
  output logic [31:0]     wb_elo1,
  output logic [9:0]      wb_asid
);

  state_e          state_q, state_d;
  tlb_req_t        req_q, req_d;
  tlb_res_t        res_q, res_d;
  logic [IDXW-1:0] idx_q, idx_d;
  logic [IDXW-1:0] fidx_q, fidx_d;
  logic [IDXW-1:0] sidx_q, sidx_d;
  logic [IDXW-1:0] fill_cnt;

  tlb_fill_ctr #(.N(TLBNUM)) u_fill (
    .clk    (clk),
    .resetn (resetn),
    .cnt    (fill_cnt)
  );

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    res_d   = res_q;
    idx_d   = idx_q;
    fidx_d  = fidx_q;
    sidx_d  = sidx_q;
    unique case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          state_d        = ST_EXEC;
          req_d.op       = req_op;
          req_d.inv_op   = req_inv_op;
          req_d.inv_asid = req_inv_asid;
          req_d.inv_vppn = req_inv_vppn;
          req_d.asid     = csr_asid;
          req_d.vppn     = csr_ehi_vppn;
          req_d.ps       = csr_ps;
          // a refill handler always installs a valid entry
          req_d.w_e      = (csr_ecode == ECODE_TLBR) | ~csr_ne;
          req_d.g        = csr_elo0[ELO_G] & csr_elo1[ELO_G];
          req_d.lo0      = elo2lo(csr_elo0);
          req_d.lo1      = elo2lo(csr_elo1);
          idx_d          = csr_idx;
          fidx_d         = fill_cnt;
        end
      end
      ST_EXEC: begin
        state_d   = ST_RESP;
        res_d.found = s_found;
        res_d.e   = tlb_r_e;
        res_d.hi  = tlb_r_hi;
        res_d.g   = tlb_r_g;
        res_d.lo0 = tlb_r_lo0;
        res_d.lo1 = tlb_r_lo1;
        sidx_d    = s_index;
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
      req_q   <= '0;
      res_q   <= '0;
      idx_q   <= '0;
      fidx_q  <= '0;
      sidx_q  <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      res_q   <= res_d;
      idx_q   <= idx_d;
      fidx_q  <= fidx_d;
      sidx_q  <= sidx_d;
    end
  end

  logic is_srch, is_rd, is_wr, is_inv;

  assign is_srch = (req_q.op == TLBOP_SRCH);
  assign is_rd   = (req_q.op == TLBOP_RD);
  assign is_wr   = (req_q.op == TLBOP_WR) | (req_q.op == TLBOP_FILL);
  assign is_inv  = (req_q.op == TLBOP_INV);

  always_comb begin
    req_ready   = (state_q == ST_IDLE);
    s_sel       = 1'b0;
    s_vppn      = '0;
    s_asid      = '0;
    tlb_we      = 1'b0;
    tlb_w_index = '0;
    tlb_w_e     = 1'b0;
    tlb_w_hi    = '0;
    tlb_w_g     = 1'b0;
    tlb_w_lo0   = '0;
    tlb_w_lo1   = '0;
    tlb_r_index = '0;
    inv_valid   = 1'b0;
    inv_op      = '0;
    resp_valid  = 1'b0;
    wb_idx_we   = 1'b0;
    wb_ehi_we   = 1'b0;
    wb_elo_we   = 1'b0;
    wb_asid_we  = 1'b0;
    wb_idx      = '0;
    wb_ps       = '0;
    wb_ne       = 1'b0;
    wb_ehi_vppn = '0;
    wb_elo0     = '0;
    wb_elo1     = '0;
    wb_asid     = '0;
    if (state_q == ST_EXEC) begin
      unique case (1'b1)
        is_srch: begin
          s_sel  = 1'b1;
          s_vppn = req_q.vppn;
          s_asid = req_q.asid;
        end
        is_rd: tlb_r_index = idx_q;
        is_wr: begin
          tlb_we      = 1'b1;
          tlb_w_index = (req_q.op == TLBOP_FILL) ? fidx_q : idx_q;
          tlb_w_e     = req_q.w_e;
          tlb_w_hi    = {req_q.vppn, req_q.ps, req_q.asid};
          tlb_w_g     = req_q.g;
          tlb_w_lo0   = req_q.lo0;
          tlb_w_lo1   = req_q.lo1;
        end
        is_inv: begin
          inv_valid = 1'b1;
          inv_op    = req_q.inv_op;
          s_sel     = 1'b1;
          s_vppn    = req_q.inv_vppn;
          s_asid    = req_q.inv_asid;
        end
        default: ;
      endcase
    end
    if (state_q == ST_RESP) begin
      resp_valid = 1'b1;
      unique case (1'b1)
        is_srch: begin
          wb_idx_we = 1'b1;
          wb_ne     = ~res_q.found;
          wb_idx    = res_q.found ? sidx_q : idx_q;
        end
        is_rd: begin
          wb_idx_we  = 1'b1;
          wb_ehi_we  = 1'b1;
          wb_elo_we  = 1'b1;
          wb_asid_we = 1'b1;
          wb_idx     = idx_q;
          if (res_q.e) begin
            wb_ps       = res_q.hi[HI_PS_LSB +: PS_W];
            wb_ehi_vppn = res_q.hi[HI_VPPN_LSB +: VPPN_W];
            wb_asid     = res_q.hi[HI_ASID_LSB +: ASID_W];
            wb_elo0     = lo2elo(res_q.lo0, res_q.g);
            wb_elo1     = lo2elo(res_q.lo1, res_q.g);
          end else begin
            wb_ne = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_tlb_op_ctrl.sv
// Bench for tlb_op_ctrl: behavioural TLB array plus a
// reference model of TLB contents and CSR writeback rules.
module tb_tlb_op_ctrl;

  localparam int TLBNUM = 16;
  localparam int IDXW = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic resetn;
  logic req_valid, req_ready;
  logic [2:0] req_op;
  logic [4:0] req_inv_op;
  logic [9:0] req_inv_asid;
  logic [18:0] req_inv_vppn;
  logic [9:0] csr_asid;
  logic [18:0] csr_ehi_vppn;
  logic [IDXW-1:0] csr_idx;
  logic [5:0] csr_ps;
  logic csr_ne;
  logic [5:0] csr_ecode;
  logic [31:0] csr_elo0, csr_elo1;
  logic s_sel;
  logic [18:0] s_vppn;
  logic [9:0] s_asid;
  logic s_found;
  logic [IDXW-1:0] s_index;
  logic tlb_we;
  logic [IDXW-1:0] tlb_w_index;
  logic tlb_w_e;
  logic [34:0] tlb_w_hi;
  logic tlb_w_g;
  logic [25:0] tlb_w_lo0, tlb_w_lo1;
  logic [IDXW-1:0] tlb_r_index;
  logic tlb_r_e;
  logic [34:0] tlb_r_hi;
  logic tlb_r_g;
  logic [25:0] tlb_r_lo0, tlb_r_lo1;
  logic inv_valid;
  logic [4:0] inv_op;
  logic resp_valid;
  logic wb_idx_we, wb_ehi_we, wb_elo_we, wb_asid_we;
  logic [IDXW-1:0] wb_idx;
  logic [5:0] wb_ps;
  logic wb_ne;
  logic [18:0] wb_ehi_vppn;
  logic [31:0] wb_elo0, wb_elo1;
  logic [9:0] wb_asid;

  tlb_op_ctrl #(.TLBNUM(TLBNUM)) dut (
    .clk(clk), .resetn(resetn),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_inv_op(req_inv_op),
    .req_inv_asid(req_inv_asid), .req_inv_vppn(req_inv_vppn),
    .csr_asid(csr_asid), .csr_ehi_vppn(csr_ehi_vppn),
    .csr_idx(csr_idx), .csr_ps(csr_ps), .csr_ne(csr_ne),
    .csr_ecode(csr_ecode), .csr_elo0(csr_elo0), .csr_elo1(csr_elo1),
    .s_sel(s_sel), .s_vppn(s_vppn), .s_asid(s_asid),
    .s_found(s_found), .s_index(s_index),
    .tlb_we(tlb_we), .tlb_w_index(tlb_w_index), .tlb_w_e(tlb_w_e),
    .tlb_w_hi(tlb_w_hi), .tlb_w_g(tlb_w_g),
    .tlb_w_lo0(tlb_w_lo0), .tlb_w_lo1(tlb_w_lo1),
    .tlb_r_index(tlb_r_index), .tlb_r_e(tlb_r_e), .tlb_r_hi(tlb_r_hi),
    .tlb_r_g(tlb_r_g), .tlb_r_lo0(tlb_r_lo0), .tlb_r_lo1(tlb_r_lo1),
    .inv_valid(inv_valid), .inv_op(inv_op),
    .resp_valid(resp_valid),
    .wb_idx_we(wb_idx_we), .wb_ehi_we(wb_ehi_we),
    .wb_elo_we(wb_elo_we), .wb_asid_we(wb_asid_we),
    .wb_idx(wb_idx), .wb_ps(wb_ps), .wb_ne(wb_ne),
    .wb_ehi_vppn(wb_ehi_vppn), .wb_elo0(wb_elo0), .wb_elo1(wb_elo1),
    .wb_asid(wb_asid)
  );

  // environment TLB array driven by the DUT's strobes
  logic env_clr;
  logic [TLBNUM-1:0] env_e;
  logic [TLBNUM-1:0] env_g;
  logic [34:0] env_hi [TLBNUM];
  logic [25:0] env_lo0 [TLBNUM];
  logic [25:0] env_lo1 [TLBNUM];

  always @(posedge clk) begin
    if (env_clr) begin
      env_e <= '0;
      env_g <= '0;
    end else if (tlb_we) begin
      env_e[tlb_w_index]   <= tlb_w_e;
      env_g[tlb_w_index]   <= tlb_w_g;
      env_hi[tlb_w_index]  <= tlb_w_hi;
      env_lo0[tlb_w_index] <= tlb_w_lo0;
      env_lo1[tlb_w_index] <= tlb_w_lo1;
    end
  end

  assign tlb_r_e   = env_e[tlb_r_index];
  assign tlb_r_g   = env_g[tlb_r_index];
  assign tlb_r_hi  = env_hi[tlb_r_index];
  assign tlb_r_lo0 = env_lo0[tlb_r_index];
  assign tlb_r_lo1 = env_lo1[tlb_r_index];

  always_comb begin
    s_found = 1'b0;
    s_index = '0;
    for (int i = TLBNUM - 1; i >= 0; i--) begin
      if (env_e[i] && env_hi[i][34:16] == s_vppn &&
          (env_g[i] || env_hi[i][9:0] == s_asid)) begin
        s_found = 1'b1;
        s_index = 4'(i);
      end
    end
  end

  // cycles since reset release: the fill index is this mod TLBNUM
  int cyc;
  always @(posedge clk or negedge resetn) begin
    if (!resetn) cyc <= 0;
    else         cyc <= cyc + 1;
  end

  // reference model of what software expects to be in the TLB
  bit        ref_e    [TLBNUM];
  bit [18:0] ref_vppn [TLBNUM];
  bit [5:0]  ref_ps   [TLBNUM];
  bit [9:0]  ref_asid [TLBNUM];
  bit        ref_g    [TLBNUM];
  bit [31:0] ref_elo0 [TLBNUM];
  bit [31:0] ref_elo1 [TLBNUM];

  int n_assert = 0;
  int n_fail = 0;

  logic any_out;
  assign any_out = |{resp_valid, wb_idx_we, wb_ehi_we, wb_elo_we,
                     wb_asid_we, wb_idx, wb_ps, wb_ne, wb_ehi_vppn,
                     wb_elo0, wb_elo1, wb_asid, s_sel, s_vppn, s_asid,
                     tlb_we, tlb_w_index, tlb_w_e, tlb_w_hi, tlb_w_g,
                     tlb_w_lo0, tlb_w_lo1, tlb_r_index, inv_valid, inv_op};

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [25:0] pack_lo(input logic [31:0] e);
    return {e[27:8], e[3:2], e[5:4], e[1], e[0]};
  endfunction

  // called at a negedge with the DUT idle; returns at the negedge
  // where the DUT is idle again, three cycles later
  task automatic do_op(input logic [2:0] op, input logic [4:0] iop,
                       input logic [9:0] iasid, input logic [18:0] ivppn,
                       input logic [9:0] asid, input logic [18:0] vppn,
                       input logic [3:0] idx, input logic [5:0] ps,
                       input logic ne, input logic [5:0] ec,
                       input logic [31:0] e0, input logic [31:0] e1);
    logic srch, rd, wr, inv, we_e, g, hit;
    logic [3:0] fidx, widx, hidx;
    logic [3:0] x_we, x_idx;
    logic x_ne;
    logic [5:0] x_ps;
    logic [18:0] x_vppn;
    logic [9:0] x_asid;
    logic [31:0] x_elo0, x_elo1;
    req_op = op; req_inv_op = iop;
    req_inv_asid = iasid; req_inv_vppn = ivppn;
    csr_asid = asid; csr_ehi_vppn = vppn; csr_idx = idx;
    csr_ps = ps; csr_ne = ne; csr_ecode = ec;
    csr_elo0 = e0; csr_elo1 = e1;
    req_valid = 1'b1;
    chk("idle_ready", req_ready, 1);
    chk("idle_quiet", {resp_valid, tlb_we, inv_valid, s_sel}, 0);
    fidx = 4'(cyc % TLBNUM);
    srch = (op == 3'd0);
    rd   = (op == 3'd1);
    wr   = (op == 3'd2) || (op == 3'd3);
    inv  = (op == 3'd4);
    widx = (op == 3'd3) ? fidx : idx;
    we_e = (ec == 6'h3F) || !ne;
    g    = e0[6] & e1[6];
    hit  = 1'b0;
    hidx = '0;
    for (int i = TLBNUM - 1; i >= 0; i--) begin
      if (ref_e[i] && ref_vppn[i] == vppn &&
          (ref_g[i] || ref_asid[i] == asid)) begin
        hit = 1'b1;
        hidx = 4'(i);
      end
    end
    @(negedge clk);
    req_valid = 1'b0;
    req_op = 3'($urandom); req_inv_op = 5'($urandom);
    req_inv_asid = 10'($urandom); req_inv_vppn = 19'($urandom);
    csr_asid = 10'($urandom); csr_ehi_vppn = 19'($urandom);
    csr_idx = 4'($urandom); csr_ps = 6'($urandom);
    csr_ne = 1'($urandom); csr_ecode = 6'($urandom);
    csr_elo0 = $urandom; csr_elo1 = $urandom;
    chk("exec_ready", req_ready, 0);
    chk("exec_wb", {resp_valid, wb_idx_we, wb_ehi_we, wb_elo_we,
                    wb_asid_we}, 0);
    chk("exec_strobes", {tlb_we, inv_valid, s_sel},
        {wr, inv, srch | inv});
    chk("exec_s_ops", {s_vppn, s_asid},
        srch ? {vppn, asid} : inv ? {ivppn, iasid} : 29'd0);
    chk("exec_inv_op", inv_op, inv ? iop : 5'd0);
    chk("exec_r_index", tlb_r_index, rd ? idx : 4'd0);
    chk("exec_w_ctl", {tlb_w_index, tlb_w_e, tlb_w_g},
        wr ? {widx, we_e, g} : 6'd0);
    chk("exec_w_hi", tlb_w_hi, wr ? {vppn, ps, asid} : 35'd0);
    chk("exec_w_lo", {tlb_w_lo0, tlb_w_lo1},
        wr ? {pack_lo(e0), pack_lo(e1)} : 52'd0);
    @(negedge clk);
    x_we = '0; x_idx = '0; x_ne = 1'b0; x_ps = '0;
    x_vppn = '0; x_asid = '0; x_elo0 = '0; x_elo1 = '0;
    if (srch) begin
      x_we  = 4'b1000;
      x_ne  = !hit;
      x_idx = hit ? hidx : idx;
    end else if (rd) begin
      x_we  = 4'b1111;
      x_idx = idx;
      if (ref_e[idx]) begin
        x_ps   = ref_ps[idx];
        x_vppn = ref_vppn[idx];
        x_asid = ref_asid[idx];
        x_elo0 = (ref_elo0[idx] & 32'h0FFF_FF3F) |
                 {25'd0, ref_g[idx], 6'd0};
        x_elo1 = (ref_elo1[idx] & 32'h0FFF_FF3F) |
                 {25'd0, ref_g[idx], 6'd0};
      end else begin
        x_ne = 1'b1;
      end
    end
    chk("resp_valid", resp_valid, 1);
    chk("resp_ready", req_ready, 0);
    chk("resp_tlb_quiet", {tlb_we, inv_valid, s_sel, tlb_r_index}, 0);
    chk("resp_we", {wb_idx_we, wb_ehi_we, wb_elo_we, wb_asid_we}, x_we);
    chk("resp_idx", {wb_ne, wb_idx, wb_ps}, {x_ne, x_idx, x_ps});
    chk("resp_ehi", {wb_ehi_vppn, wb_asid}, {x_vppn, x_asid});
    chk("resp_elo", {wb_elo0, wb_elo1}, {x_elo0, x_elo1});
    if (wr) begin
      ref_e[widx] = we_e; ref_vppn[widx] = vppn;
      ref_ps[widx] = ps; ref_asid[widx] = asid;
      ref_g[widx] = g; ref_elo0[widx] = e0; ref_elo1[widx] = e1;
    end
    @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired before summary");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0] rop;
    logic [18:0] rv;
    for (int i = 0; i < TLBNUM; i++) begin
      ref_e[i] = 0; ref_vppn[i] = 0; ref_ps[i] = 0; ref_asid[i] = 0;
      ref_g[i] = 0; ref_elo0[i] = 0; ref_elo1[i] = 0;
    end
    env_clr = 1'b1;
    req_valid = 1'b0; req_op = '0; req_inv_op = '0;
    req_inv_asid = '0; req_inv_vppn = '0;
    csr_asid = '0; csr_ehi_vppn = '0; csr_idx = '0; csr_ps = '0;
    csr_ne = 1'b0; csr_ecode = '0; csr_elo0 = '0; csr_elo1 = '0;
    resetn = 1'b1;
    #1 resetn = 1'b0;
    #1;
    chk("reset_ready", req_ready, 1);
    chk("reset_outputs_zero", any_out, 0);
    repeat (2) @(negedge clk);
    env_clr = 1'b0;
    chk("reset_hold_outputs_zero", any_out, 0);
    resetn = 1'b1;

    // write entry 5, then search hit / miss and read it back
    do_op(3'd2, 0, 0, 0, 10'd3, 19'h12345, 4'd5, 6'd12, 1'b0, 6'd0,
          32'hF123_45DF, 32'h0987_65C6);
    do_op(3'd0, 0, 0, 0, 10'd3, 19'h12345, 4'd2, 6'd0, 1'b0, 6'd0,
          0, 0);
    do_op(3'd0, 0, 0, 0, 10'd3, 19'h00001, 4'd7, 6'd0, 1'b0, 6'd0,
          0, 0);
    do_op(3'd1, 0, 0, 0, 0, 0, 4'd5, 6'd0, 1'b0, 6'd0, 0, 0);
    do_op(3'd1, 0, 0, 0, 0, 0, 4'd9, 6'd0, 1'b0, 6'd0, 0, 0);
    // NE handling and refill override, mixed global bits
    do_op(3'd2, 0, 0, 0, 10'd7, 19'h0ABCD, 4'd6, 6'd21, 1'b1, 6'd0,
          32'h0000_1153, 32'h0000_2242);
    do_op(3'd2, 0, 0, 0, 10'd7, 19'h0ABCD, 4'd6, 6'd21, 1'b1, 6'h3F,
          32'h0000_0041, 32'h0000_0003);
    do_op(3'd1, 0, 0, 0, 0, 0, 4'd6, 6'd0, 1'b0, 6'd0, 0, 0);
    // FILL at counter 15 then back to back
    for (int k = 0; k < 2 * TLBNUM && (cyc % TLBNUM) != 15; k++)
      @(negedge clk);
    do_op(3'd3, 0, 0, 0, 10'd1, 19'h11111, 4'd0, 6'd12, 1'b0, 6'd0,
          32'h0000_0103, 32'h0000_0203);
    do_op(3'd3, 0, 0, 0, 10'd1, 19'h22222, 4'd0, 6'd12, 1'b0, 6'd0,
          32'h0000_0303, 32'h0000_0403);
    do_op(3'd1, 0, 0, 0, 0, 0, 4'd15, 6'd0, 1'b0, 6'd0, 0, 0);
    do_op(3'd4, 5'd5, 10'd3, 19'h12345, 10'd9, 19'h7FFFF, 4'd3,
          6'd1, 1'b1, 6'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    do_op(3'd6, 5'd1, 10'd1, 19'h1, 10'd3, 19'h12345, 4'd5, 6'd12,
          1'b0, 6'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);

    // reset while in EXEC aborts the op
    req_op = 3'd0; csr_ehi_vppn = 19'h12345; csr_asid = 10'd3;
    req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    chk("abort_in_exec", s_sel, 1);
    resetn = 1'b0;
    #1;
    chk("abort_ready", req_ready, 1);
    chk("abort_outputs_zero", any_out, 0);
    repeat (3) begin
      @(negedge clk);
      chk("abort_no_resp", resp_valid, 0);
    end
    resetn = 1'b1;
    @(negedge clk);
    chk("abort_release_quiet", {resp_valid, req_ready}, 2'b01);

    for (int n = 0; n < 80; n++) begin
      rop = 3'($urandom_range(0, 7));
      case ($urandom_range(0, 2))
        0: rv = 19'h12345;
        1: rv = 19'h00001;
        default: rv = 19'($urandom_range(0, 3));
      endcase
      do_op(rop, 5'($urandom), 10'($urandom), 19'($urandom),
            10'($urandom_range(0, 3)), rv, 4'($urandom), 6'($urandom),
            1'($urandom), ($urandom_range(0, 1) == 1) ? 6'h3F : 6'd0,
            $urandom, $urandom);
    end
    chk("final_idle", {req_ready, resp_valid}, 2'b10);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/tlb_op_ctrl.md
# tlb_op_ctrl

Sequencer for LoongArch TLB management instructions: TLBSRCH, TLBRD, TLBWR, TLBFILL and INVTLB. Sits directly upstream of the `tlb` array. It accepts one decoded TLB op from the WB-stage instruction path and drives the TLB write, read, invtlb and search-port-1 inputs for one cycle. It then returns the CSR writeback fields (TLBIDX, TLBEHI, TLBELO0/1, ASID) to the CSR file.

## Interface
- `TLBNUM`, 16: number of TLB entries. `IDXW` = $clog2(TLBNUM).
- `clk` in 1: clock.
- `resetn` in 1: asynchronous, active-low reset.
- `req_valid` in 1 / `req_ready` out 1: op handshake.
- `req_op` in 3: 0 SRCH, 1 RD, 2 WR, 3 FILL, 4 INV; 5-7 complete with no side effect.
- `req_inv_op` in 5: invtlb opcode.
- `req_inv_asid` in 10: invtlb ASID operand.
- `req_inv_vppn` in 19: invtlb VA[31:13] operand.
- `csr_asid` in 10: CSR ASID.ASID.
- `csr_ehi_vppn` in 19: TLBEHI.VPPN.
- `csr_idx` in IDXW: TLBIDX.Index.
- `csr_ps` in 6: TLBIDX.PS.
- `csr_ne` in 1: TLBIDX.NE.
- `csr_ecode` in 6: ESTAT.Ecode.
- `csr_elo0` in 32, `csr_elo1` in 32: TLBELO layout. V[0], D[1], PLV[3:2], MAT[5:4], G[6], PPN[27:8].
- `s_sel` out 1: claims tlb search port 1; the external mux selects this block's operands.
- `s_vppn` out 19, `s_asid` out 10: search operands.
- `s_found` in 1, `s_index` in IDXW: search result.
- `tlb_we` out 1, `tlb_w_index` out IDXW, `tlb_w_e` out 1.
- `tlb_w_hi` out 35: {vppn[18:0], ps[5:0], asid[9:0]}.
- `tlb_w_g` out 1.
- `tlb_w_lo0` out 26, `tlb_w_lo1` out 26: each {ppn[19:0], plv[1:0], mat[1:0], d, v}.
- `tlb_r_index` out IDXW.
- `tlb_r_e` in 1, `tlb_r_hi` in 35, `tlb_r_g` in 1, `tlb_r_lo0` in 26, `tlb_r_lo1` in 26: read port, same packing.
- `inv_valid` out 1, `inv_op` out 5: invtlb strobe and opcode.
- `resp_valid` out 1: one-cycle completion pulse.
- `wb_idx_we`, `wb_ehi_we`, `wb_elo_we`, `wb_asid_we` out 1 each: CSR write enables, valid only with `resp_valid`.
- `wb_idx` out IDXW, `wb_ps` out 6, `wb_ne` out 1, `wb_ehi_vppn` out 19, `wb_elo0` out 32, `wb_elo1` out 32, `wb_asid` out 10: CSR write data.

## Operation
- FSM states: IDLE, EXEC, RESP.
- IDLE: `req_ready`=1. On `req_valid&req_ready`, latch op, operands and all CSR inputs, then go to EXEC.
- EXEC (1 cycle): drive the TLB from the latched values only, then go to RESP.
  - SRCH: `s_sel`=1, `s_vppn`=ehi_vppn, `s_asid`=asid. Register `s_found` and `s_index` at the end of the cycle.
  - RD: `tlb_r_index`=idx. Register the read outputs.
  - WR: `tlb_we`=1, index = idx.
  - FILL: `tlb_we`=1, index = fill counter value sampled at accept.
  - WR/FILL write data:
    - `w_e` = (ecode==6'h3F) ? 1 : ~ne.
    - hi = {ehi_vppn, ps, asid}.
    - g = elo0.G & elo1.G.
    - lo fields are taken from elo.
  - INV: `inv_valid`=1, `inv_op`=req_inv_op, `s_sel`=1, `s_asid`=req_inv_asid, `s_vppn`=req_inv_vppn.
- RESP (1 cycle): `resp_valid`=1, then go to IDLE. Write enables by op:
  - SRCH: `wb_idx_we`=1. Found gives `wb_ne`=0, `wb_idx`=s_index. Miss gives `wb_ne`=1 with `wb_idx`=latched idx (index unchanged).
  - RD, entry valid (E=1): all four enables set, `wb_ne`=0, fields unpacked from the read data, elo.G = r_g, elo bits [31:28] and [7] = 0.
  - RD, entry invalid (E=0): all four enables set, `wb_ne`=1, `wb_ps`=0, ehi/elo/asid = 0, `wb_idx` = latched idx.
  - WR/FILL/INV/reserved ops: no enables.
- Fill counter: IDXW bits, free-running, +1 every cycle, wraps TLBNUM-1 → 0.
- Outside EXEC, all TLB-drive outputs are 0. Outside RESP, all `wb_*` outputs are 0.

## Timing
- Reset (async assert): state IDLE, counter 0, every output 0 except `req_ready`=1. A reset mid-op aborts it with no `resp_valid`.
- Latency: accept at cycle N, TLB strobe at N+1, `resp_valid` at N+2. Throughput is one op per 3 cycles. `req_ready`=0 in EXEC and RESP.
- The TLB write commits at the clock edge ending EXEC, so a following op sees the new entry.
- `tlb_we` and `inv_valid` are never asserted together.

## Structure
- Shared package `tlb_pkg`:
  - op encodings (`TLBOP_*`);
  - ecode constant `ECODE_TLBR`=6'h3F;
  - hi/lo field widths and bit offsets;
  - TLBELO bit positions.
- Sub-module `tlb_fill_ctr`: the wrapping free-running index counter.
- Everything else stays flat.

## Test plan
- SRCH hit: write entry 5 with vppn 0x12345 and asid 3, then SRCH with the same values -> `wb_idx`=5, `wb_ne`=0, only `wb_idx_we` set.
- SRCH miss on vppn 0x00001 -> `wb_ne`=1, `wb_idx` unchanged.
- RD of entry 5 -> round-trip of ppn0/ppn1/plv/mat/d/v/g/ps/asid. RD of an invalid entry -> `wb_ne`=1 and zeros everywhere else.
- WR with ne=1, ecode=0 -> `tlb_w_e`=0. WR with ne=1, ecode=0x3F -> `tlb_w_e`=1. elo0.G=1, elo1.G=0 -> `tlb_w_g`=0.
- FILL issued at counter 15 -> index 15, counter wraps to 0. Back-to-back FILLs land on distinct indices.
- INV op 5 with asid 3, vppn 0x12345 -> `inv_valid` for exactly 1 cycle, `s_sel`=1. resetn asserted during EXEC -> no `resp_valid`, outputs 0.
